// File: rtl/ifetch_pkg.sv
// Shared core constants and the fetch-buffer entry format for the instruction-fetch stage.
`default_nettype none

package ifetch_pkg;
  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [ILEN-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/ifetch_unit_fifo.sv
// Synchronous FIFO with flush; head is read straight from storage (no bypass).
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr, r_wptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != C_FULL) || w_pop);

  // Explicit wrap keeps pointers correct for non-power-of-two depths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + AW'(1);
      if (w_pop)  r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// Instruction fetch: credit-limited req/gnt issue from pc_i, in-order response
// tracking, stale-response dropping after jumps, and a decode-facing buffer.
`default_nettype none

module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            jump_en_i,
  output logic            hold_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_ready_i
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [OW-1:0]      w_outstanding, w_out_next, r_drop, w_drop_next;
  logic [CW-1:0]      w_count;
  logic [XLEN-1:0]    w_rsp_addr;
  logic [$bits(fetch_entry_t)-1:0] w_head_raw;
  fetch_entry_t       w_head, w_push_entry;
  logic               w_pop, w_issue, w_keep, w_credit_ok;
  int                 w_inflight, w_buffered;

  assign w_pop = inst_valid_o && inst_ready_i;

  // Words already owed to the buffer plus words staying in it must fit.
  always_comb begin
    w_inflight  = 32'(w_outstanding) - 32'(r_drop);
    w_buffered  = 32'(w_count) - 32'(w_pop);
    w_credit_ok = ((w_inflight + w_buffered) < FIFO_DEPTH) &&
                  (32'(w_outstanding) < MAX_OUTSTANDING);
  end

  assign imem_req_o  = w_credit_ok && !jump_en_i && rst;
  assign imem_addr_o = pc_i;
  assign w_issue     = imem_req_o && imem_gnt_i;
  assign hold_o      = !w_issue || jump_en_i;

  assign w_out_next = w_outstanding + OW'(w_issue) - OW'(imem_rvalid_i);
  assign w_keep     = imem_rvalid_i && (r_drop == '0) && !jump_en_i;

  always_comb begin
    w_drop_next = r_drop;
    if (jump_en_i)
      w_drop_next = w_out_next;
    else if (imem_rvalid_i && (r_drop != '0))
      w_drop_next = r_drop - OW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_drop <= '0;
    else      r_drop <= w_drop_next;
  end

  // The address queue occupancy doubles as the outstanding-request count.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_issue),
    .i_pop   (imem_rvalid_i),
    .i_wdata (pc_i),
    .o_rdata (w_rsp_addr),
    .o_count (w_outstanding)
  );

  assign w_push_entry = '{addr: w_rsp_addr, inst: imem_rdata_i};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (jump_en_i),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head_raw),
    .o_count (w_count)
  );

  assign w_head       = w_head_raw;
  assign inst_valid_o = (w_count != '0);
  assign inst_o       = inst_valid_o ? w_head.inst : '0;
  assign inst_addr_o  = inst_valid_o ? w_head.addr : '0;
endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit with an epoch-based memory/PC/decode reference model.
`default_nettype none

module tb_ifetch_unit;
  localparam int FD = 2;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        jump_en_i = 1'b0;
  logic        hold_o, imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .jump_en_i     (jump_en_i),
    .hold_o        (hold_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ready_i  (inst_ready_i)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] inst; } ent_t;

  req_t        pend[$];
  ent_t        bufq[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, epoch = 0, last_due = 0;
  int          gnt_pct, rdy_pct, jmp_pct, lat_max;
  logic [31:0] pc_m = '0, exp_next = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic run_cycle();
    logic jmp, gnt, rdy, rv, pop, req_e, issue;
    logic [31:0] tgt;
    int nonstale, lat;
    req_t r;
    @(posedge clk);
    cyc++;
    #1;
    jmp = ($urandom_range(99) < jmp_pct);
    gnt = ($urandom_range(99) < gnt_pct);
    rdy = ($urandom_range(99) < rdy_pct);
    tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
    rv  = (pend.size() > 0) && (pend[0].due <= cyc);
    pc_i          = pc_m;
    jump_en_i     = jmp;
    imem_gnt_i    = gnt;
    inst_ready_i  = rdy;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
    #3;
    pop = (bufq.size() > 0) && rdy;
    nonstale = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) nonstale++;
    req_e = !jmp && ((nonstale + bufq.size() - int'(pop)) < FD) && (pend.size() < MO);
    issue = req_e && gnt;

    check_val("inst_valid", inst_valid_o, bufq.size() > 0);
    check_val("inst_addr", inst_addr_o, (bufq.size() > 0) ? bufq[0].addr : 32'h0);
    check_val("inst_data", inst_o, (bufq.size() > 0) ? bufq[0].inst : 32'h0);
    check_val("imem_req", imem_req_o, req_e);
    if (req_e) check_val("imem_addr", imem_addr_o, pc_m);
    check_val("hold", hold_o, !issue || jmp);

    if (pop) begin
      check_val("stream_addr", inst_addr_o, exp_next);
      exp_next = exp_next + 32'd4;
      void'(bufq.pop_front());
    end
    if (jmp) bufq.delete();
    if (rv) begin
      r = pend.pop_front();
      if (!jmp && r.epoch == epoch) begin
        check_val("buffer_room", bufq.size() < FD, 1'b1);
        bufq.push_back('{addr: r.addr, inst: mem_word(r.addr)});
      end
    end
    if (issue) begin
      lat = $urandom_range(1, lat_max);
      r.addr  = pc_m;
      r.epoch = epoch;
      r.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      pend.push_back(r);
    end
    if (jmp) begin
      epoch++;
      pc_m = tgt;
      exp_next = tgt;
    end else if (issue) begin
      pc_m = pc_m + 32'd4;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    bufq.delete();
    epoch++;
    pc_m = '0;
    exp_next = '0;
    last_due = 0;
    pc_i = '0;
    jump_en_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_inst_valid", inst_valid_o, 1'b0);
    check_val("rst_req", imem_req_o, 1'b0);
    check_val("rst_hold", hold_o, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic phase(input int g, input int rd, input int j, input int l, input int n);
    gnt_pct = g; rdy_pct = rd; jmp_pct = j; lat_max = l;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    #12;
    check_val("reset_valid", inst_valid_o, 1'b0);
    check_val("reset_inst", inst_o, 32'h0);
    check_val("reset_addr", inst_addr_o, 32'h0);
    check_val("reset_req", imem_req_o, 1'b0);
    check_val("reset_hold", hold_o, 1'b1);
    #5;
    rst = 1'b1;
    phase(100, 100, 0, 1, 20);
    phase(0, 100, 0, 1, 3);
    phase(50, 100, 0, 1, 30);
    phase(100, 0, 0, 1, 10);
    phase(100, 100, 0, 1, 10);
    phase(100, 100, 10, 3, 200);
    phase(100, 100, 0, 1, 10);
    async_reset();
    phase(100, 100, 0, 1, 20);
    phase(70, 60, 8, 4, 1500);
    async_reset();
    phase(80, 70, 5, 3, 1500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues ordered requests to instruction memory over a req/gnt + rvalid bus, and buffers the returned words in a small FIFO for decode (valid/ready).
- Drives the PC register's hold input so the PC advances only when an address has been accepted by memory.
- On a jump, discards all stale in-flight and buffered instructions.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, ≥2); also the credit limit for in-flight plus buffered fetches.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered memory requests (≤ FIFO_DEPTH).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- pc_i  in  32  current PC from PC register
- jump_en_i  in  1  redirect from execute; flush stale fetches
- hold_o  out  1  to PC register hold input; 1 = PC must not increment
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (= pc_i)
- imem_gnt_i  in  1  memory accepted request this cycle
- imem_rvalid_i  in  1  response valid (in request order, latency ≥1)
- imem_rdata_i  in  32  instruction word
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  32  FIFO head instruction
- inst_addr_o  out  32  address of FIFO head instruction
- inst_ready_i  in  1  decode consumes head when valid & ready

Behaviour:
- Reset (rst=0, async): FIFO empty, outstanding=0, drop_cnt=0, address queue empty.
- Reset output values: inst_valid_o=0, inst_o=0, inst_addr_o=0, imem_req_o=0, hold_o=1.
- pop = inst_valid_o & inst_ready_i.
- credit_ok = (outstanding − drop_cnt) + (count − pop) < FIFO_DEPTH, and outstanding < MAX_OUTSTANDING.
- imem_req_o = credit_ok & ~jump_en_i & rst deasserted; imem_addr_o = pc_i. Combinational.
- issue = imem_req_o & imem_gnt_i. On issue, pc_i is pushed into an address queue (depth MAX_OUTSTANDING) and outstanding increments.
- hold_o = ~issue | jump_en_i.
  - The PC increments by 4 exactly on issue cycles.
  - On a jump, hold_o=1 so the PC register loads the jump address.
- Response handling: each imem_rvalid_i decrements outstanding and pops the address queue.
  - If drop_cnt>0 or jump_en_i=1 that cycle, the word is discarded (drop_cnt decrements when >0).
  - Otherwise {addr, rdata} is pushed to the FIFO.
- Latency: gnt in cycle N, rvalid in cycle N+k (k≥1), inst_valid_o=1 in cycle N+k+1 (registered FIFO, no bypass).
- Throughput: 1 instruction/cycle sustained with k=1, FIFO_DEPTH=2, inst_ready_i=1.
- Jump (jump_en_i=1), all in one cycle:
  - FIFO cleared; inst_valid_o=0 next cycle.
  - No request issued.
  - drop_cnt_next = outstanding_next, i.e. every request still in flight after this cycle is stale.
  - First fetch of the target occurs the following cycle.
- Simultaneous pop and push: both happen; count unchanged.
- Simultaneous jump and pop: flush wins; the popped instruction was still delivered to decode this cycle.
- Back-to-back jumps: each recomputes drop_cnt from outstanding; no stale word ever reaches the FIFO.
- Full: credit accounting makes push into a full FIFO impossible; an rvalid arriving on a full FIFO is a bench-checked assertion error.
- imem_rvalid_i with outstanding=0 is an assertion error.
- Address and PC arithmetic are 32-bit and wrap modulo 2^32.
- Reset asserted mid-operation: all state cleared immediately. In-flight responses arriving after reset release are not expected; the memory is reset by the same rst.

Decomposition:
- Shared core package holds XLEN=32, instruction width, INST_BYTES=4, and NOP encoding 32'h00000013.
- One natural sub-module: sync_fifo, parameterised width/depth with push/pop/count/flush. Used for both the instruction buffer (64-bit entries) and the address queue (32-bit).

Test Plan:
- Reset release, memory gnt=1, latency 1, ready=1, PC starting at 0 → requests at 0,4,8,… every cycle; inst_valid_o from cycle 3; inst_addr_o 0,4,8 consecutively; hold_o=0 in steady state.
- gnt held 0 for 3 cycles → imem_req_o stays 1 with imem_addr_o constant, hold_o=1, pc_i unchanged.
- inst_ready_i=0 with latency 1 → at most 2 words buffered; imem_req_o drops; count never exceeds 2; on ready=1, instructions drain in order with no loss.
- Latency 3 with 2 requests outstanding, jump_en_i=1 to 32'h100 → both late responses discarded; next delivered inst_addr_o=32'h100; no stale address ever visible.
- jump_en_i in the same cycle as rvalid and pop → popped word consumed, rvalid word discarded, FIFO empty next cycle, hold_o=1 that cycle.
- Assert rst=0 asynchronously mid-burst → inst_valid_o and imem_req_o go 0 without a clock edge; after release, fetch resumes from pc_i=0.
